data_mem_responder: RTL and testbench

//  Memory-side responder for the datapath's load/store port: accepts one word-access request
//  at a time via valid/ready, inserts WAIT_STATES cycles of latency, then returns read data or
//  a write completion, held until the requester takes it. Replaces the zero-latency dataMemory
//  so the datapath can be exercised against a realistic, stallable memory.

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/byte_enable_ram.sv | 31 +++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-side bus responders (data port now, instruction port later).
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES       = 4;
    localparam int BYTE_OFFSET_BITS = $clog2(WORD_BYTES);
    localparam int ADDR_WIDTH       = 32;

    // True when a byte address is not word aligned or falls beyond a memory of 2**word_addr_bits words.
    function automatic logic access_fault(input logic [ADDR_WIDTH-1:0] addr,
                                          input int                    word_addr_bits);
        logic fault;
        fault = (addr[BYTE_OFFSET_BITS-1:0] != '0);
        for (int i = BYTE_OFFSET_BITS; i < ADDR_WIDTH; i++) begin
            if ((i >= word_addr_bits + BYTE_OFFSET_BITS) && addr[i]) begin
                fault = 1'b1;
            end
        end
        return fault;
    endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// Word-organised RAM with per-byte write enables, synchronous write and combinational read.
module byte_enable_ram
    import mem_bus_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 8
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [WORD_ADDR_BITS-1:0] addr,
    input  logic [WORD_BYTES-1:0]     be,
    input  logic [8*WORD_BYTES-1:0]   wdata,
    output logic [8*WORD_BYTES-1:0]   rdata
);
    localparam int DEPTH = 2 ** WORD_ADDR_BITS;

    // One independent byte-wide array per lane keeps every lane single-writer.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Stallable data-memory responder: one valid/ready request at a time, fixed wait states,
// response held until the requester accepts it.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 8,
    parameter int WAIT_STATES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t                state_reg,    state_next;
    logic [3:0]                wait_cnt_reg, wait_cnt_next;
    logic                      write_reg,    write_next;
    logic                      fault_reg,    fault_next;
    logic [WORD_ADDR_BITS-1:0] index_reg,    index_next;
    logic [31:0]               wdata_reg,    wdata_next;
    logic [3:0]                be_reg,       be_next;
    logic [31:0]               rdata_reg,    rdata_next;
    logic                      error_reg,    error_next;

    logic                      req_fault;
    logic [WORD_ADDR_BITS-1:0] req_index;
    logic                      commit;
    logic                      cur_write;
    logic                      cur_fault;
    logic [WORD_ADDR_BITS-1:0] cur_index;
    logic [31:0]               cur_wdata;
    logic [3:0]                cur_be;
    logic                      ram_we;
    logic [31:0]               ram_rdata;

    assign req_fault = access_fault(req_addr, WORD_ADDR_BITS);
    assign req_index = req_addr[WORD_ADDR_BITS+1:2];

    // With no wait states the access completes on the accept edge, so the live request is used.
    always_comb begin
        if (state_reg == IDLE) begin
            cur_write = req_write;
            cur_fault = req_fault;
            cur_index = req_index;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_write = write_reg;
            cur_fault = fault_reg;
            cur_index = index_reg;
            cur_wdata = wdata_reg;
            cur_be    = be_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        write_next    = write_reg;
        fault_next    = fault_reg;
        index_next    = index_reg;
        wdata_next    = wdata_reg;
        be_next       = be_reg;
        rdata_next    = rdata_reg;
        error_next    = error_reg;
        commit        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    fault_next = req_fault;
                    index_next = req_index;
                    wdata_next = req_wdata;
                    be_next    = req_be;
                    if (ZERO_WAIT) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        wait_cnt_next = WAIT_LOAD;
                        state_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    rdata_next = 32'd0;
                    error_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Response data is captured once; it then stays frozen for any amount of back-pressure.
        if (commit) begin
            rdata_next = (cur_write || cur_fault) ? 32'd0 : ram_rdata;
            error_next = cur_fault;
        end
    end

    assign ram_we = commit && cur_write && !cur_fault;

    byte_enable_ram #(
        .WORD_ADDR_BITS(WORD_ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (cur_index),
        .be    (cur_be),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            write_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            index_reg    <= '0;
            wdata_reg    <= 32'd0;
            be_reg       <= 4'd0;
            rdata_reg    <= 32'd0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            write_reg    <= write_next;
            fault_reg    <= fault_next;
            index_reg    <= index_next;
            wdata_reg    <= wdata_next;
            be_reg       <= be_next;
            rdata_reg    <= rdata_next;
            error_reg    <= error_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_error = error_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: the same vectors run against a 2-wait-state and a 0-wait-state instance.
module tb_data_mem_responder;

    typedef struct {
        string       name;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_error;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    bit          sel;
    int          ws;
    int          n_vec  = 0;
    int          n_fail = 0;
    vec_t        vecs[$];

    logic        req_valid_w2, req_ready_w2, rsp_valid_w2, rsp_error_w2;
    logic        req_valid_w0, req_ready_w0, rsp_valid_w0, rsp_error_w0;
    logic [31:0] rsp_rdata_w2, rsp_rdata_w0;
    logic        req_ready_m, rsp_valid_m, rsp_error_m;
    logic [31:0] rsp_rdata_m;

    always #5 clock = ~clock;

    assign req_valid_w2 = req_valid && !sel;
    assign req_valid_w0 = req_valid && sel;
    assign req_ready_m  = sel ? req_ready_w0 : req_ready_w2;
    assign rsp_valid_m  = sel ? rsp_valid_w0 : rsp_valid_w2;
    assign rsp_rdata_m  = sel ? rsp_rdata_w0 : rsp_rdata_w2;
    assign rsp_error_m  = sel ? rsp_error_w0 : rsp_error_w2;

    data_mem_responder #(.WORD_ADDR_BITS(8), .WAIT_STATES(2)) dut_w2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid_w2),
        .req_ready (req_ready_w2),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_w2),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_w2),
        .rsp_error (rsp_error_w2)
    );

    data_mem_responder #(.WORD_ADDR_BITS(8), .WAIT_STATES(0)) dut_w0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid_w0),
        .req_ready (req_ready_w0),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_w0),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_w0),
        .rsp_error (rsp_error_w0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL ws=%0d %s: got %h, expected %h", ws, name, act, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then scramble req_* to prove they were latched.
    task automatic issue(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        int waited;
        waited    = 0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        while (!req_ready_m && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check({name, " req_ready"}, 32'(req_ready_m), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = !wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        req_be    = ~be;
    endtask

    // Called #1 after the accept edge; lat counts edges from the accept edge inclusive.
    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!rsp_valid_m && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({name, " rsp_valid"}, 32'(rsp_valid_m), 32'd1);
    endtask

    task automatic access(input vec_t v);
        int lat;
        rsp_ready = 1'b1;
        issue(v.name, v.write, v.addr, v.wdata, v.be);
        wait_rsp(v.name, lat);
        check({v.name, " latency"}, 32'(lat), 32'(ws + 1));
        check({v.name, " rsp_rdata"}, rsp_rdata_m, v.exp_rdata);
        check({v.name, " rsp_error"}, 32'(rsp_error_m), 32'(v.exp_error));
        $display("ws=%0d %-14s %s addr=%h wdata=%h be=%b -> rdata=%h err=%0b lat=%0d",
                 ws, v.name, v.write ? "ST" : "LD", v.addr, v.wdata, v.be, rsp_rdata_m, rsp_error_m, lat);
        @(posedge clock);
        #1;
        check({v.name, " rsp_valid drop"}, 32'(rsp_valid_m), 32'd0);
        check({v.name, " rdata clear"}, rsp_rdata_m, 32'd0);
        check({v.name, " req_ready back"}, 32'(req_ready_m), 32'd1);
    endtask

    task automatic backpressure();
        int lat;
        rsp_ready = 1'b0;
        issue("bp load", 1'b0, 32'h10, 32'd0, 4'd0);
        wait_rsp("bp load", lat);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'd0;
        req_be    = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("bp hold rsp_valid", 32'(rsp_valid_m), 32'd1);
            check("bp hold rsp_rdata", rsp_rdata_m, 32'hDEADAAEF);
            check("bp hold req_ready", 32'(req_ready_m), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp release rsp_valid", 32'(rsp_valid_m), 32'd0);
        $display("ws=%0d bp load held 10 cycles, rdata=DEADAAEF expected, ignored store to 0x10", ws);
        access('{"bp reload", 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADAAEF, 1'b0});
    endtask

    task automatic reset_mid_wait();
        rsp_ready = 1'b1;
        issue("rst store", 1'b1, 32'h20, 32'h12345678, 4'hF);
        reset_n = 1'b0;
        #1;
        check("rst rsp_valid", 32'(rsp_valid_m), 32'd0);
        check("rst req_ready", 32'(req_ready_m), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        $display("ws=%0d store 0x12345678 to 0x20 interrupted by reset", ws);
        access('{"rst reload", 1'b0, 32'h20, 32'd0, 4'd0,
                 (ws == 0) ? 32'h12345678 : 32'hA5A5A5A5, 1'b0});
    endtask

    task automatic reset_mid_resp();
        int lat;
        rsp_ready = 1'b0;
        issue("rsp store", 1'b1, 32'h24, 32'h0BADF00D, 4'hF);
        wait_rsp("rsp store", lat);
        reset_n = 1'b0;
        #1;
        check("rsp rst rsp_valid", 32'(rsp_valid_m), 32'd0);
        check("rsp rst rsp_error", 32'(rsp_error_m), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        $display("ws=%0d store 0x0BADF00D to 0x24 response discarded by reset", ws);
        access('{"rsp reload", 1'b0, 32'h24, 32'd0, 4'd0, 32'h0BADF00D, 1'b0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        sel       = 1'b0;
        ws        = 2;
        repeat (3) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            ws  = (s == 1) ? 0 : 2;
            #1;
            check("reset req_ready", 32'(req_ready_m), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid_m), 32'd0);
            check("reset rsp_rdata", rsp_rdata_m, 32'd0);
            check("reset rsp_error", 32'(rsp_error_m), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        vecs.push_back('{"st full",     1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0});
        vecs.push_back('{"ld full",     1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0});
        vecs.push_back('{"st byte1",    1'b1, 32'h0000_0010, 32'h0000AA00, 4'b0010, 32'h0,        1'b0});
        vecs.push_back('{"ld merged",   1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDEADAAEF, 1'b0});
        vecs.push_back('{"st hi addr",  1'b1, 32'h8000_0010, 32'h0,        4'hF,    32'h0,        1'b1});
        vecs.push_back('{"ld after hi", 1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDEADAAEF, 1'b0});
        vecs.push_back('{"st word0",    1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF,    32'h0,        1'b0});
        vecs.push_back('{"ld misalign", 1'b0, 32'h0000_0013, 32'h0,        4'h0,    32'h0,        1'b1});
        vecs.push_back('{"ld half",     1'b0, 32'h0000_0002, 32'h0,        4'h0,    32'h0,        1'b1});
        vecs.push_back('{"st range",    1'b1, 32'h0000_0400, 32'h11111111, 4'hF,    32'h0,        1'b1});
        vecs.push_back('{"ld word0",    1'b0, 32'h0000_0000, 32'h0,        4'h0,    32'hCAFEF00D, 1'b0});
        vecs.push_back('{"st last",     1'b1, 32'h0000_03FC, 32'h01020304, 4'hF,    32'h0,        1'b0});
        vecs.push_back('{"ld last",     1'b0, 32'h0000_03FC, 32'h0,        4'h0,    32'h01020304, 1'b0});
        vecs.push_back('{"st 0x20",     1'b1, 32'h0000_0020, 32'hA5A5A5A5, 4'hF,    32'h0,        1'b0});
        vecs.push_back('{"ld 0x20",     1'b0, 32'h0000_0020, 32'h0,        4'h0,    32'hA5A5A5A5, 1'b0});
        vecs.push_back('{"st be0",      1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0});
        vecs.push_back('{"ld after be0",1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDEADAAEF, 1'b0});

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            ws  = (s == 1) ? 0 : 2;
            #1;
            foreach (vecs[i]) begin
                access(vecs[i]);
            end
            backpressure();
            reset_mid_wait();
            reset_mid_resp();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
